// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared CPU widths and the write-back entry record used by the
//            write-back arbiter buffer and the forwarding logic.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    // "reg" is a keyword, so the destination field is named regAddr.
    typedef struct packed {
        logic              valid;
        logic              killed;
        logic [ADDR_W-1:0] regAddr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    function automatic wb_entry_t makeEntry(input logic [ADDR_W-1:0] regAddr,
                                            input logic [DATA_W-1:0] data);
        wb_entry_t e;
        e.valid   = 1'b1;
        e.killed  = 1'b0;
        e.regAddr = regAddr;
        e.data    = data;
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter_if
// Purpose  : Pipeline / long-latency unit / register-file write bundle
//            around the write-back arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_arbiter_if #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int DEPTH  = 2
) ();
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic              pipe_wr_en;
    logic [ADDR_W-1:0] pipe_wr_reg;
    logic [DATA_W-1:0] pipe_wr_data;

    logic              lu_valid;
    logic              lu_ready;
    logic [ADDR_W-1:0] lu_wr_reg;
    logic [DATA_W-1:0] lu_wr_data;

    logic              regWrite;
    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] writeData;
    logic [c_CNT_W-1:0] buf_count;

    modport master (
        output pipe_wr_en, pipe_wr_reg, pipe_wr_data,
        output lu_valid, lu_wr_reg, lu_wr_data,
        input  lu_ready,
        input  regWrite, writeReg, writeData, buf_count
    );

    modport slave (
        input  pipe_wr_en, pipe_wr_reg, pipe_wr_data,
        input  lu_valid, lu_wr_reg, lu_wr_data,
        output lu_ready,
        output regWrite, writeReg, writeData, buf_count
    );

endinterface
`default_nettype wire

// File: rtl/wb_buffer.sv
`default_nettype none
// ============================================================================
// Module   : wb_buffer
// Purpose  : Circular FIFO of long-latency write-back entries with a
//            kill-by-register port that marks every matching entry.
// Revision : 1.0 - initial release
// ============================================================================
module wb_buffer
    import cpu_pkg::*;
#(
    parameter  int DEPTH   = 2,
    localparam int c_CNT_W = $clog2(DEPTH + 1),
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               i_push,
    input  wire logic [ADDR_W-1:0]  i_pushReg,
    input  wire logic [DATA_W-1:0]  i_pushData,
    input  wire logic               i_pop,
    input  wire logic               i_killEn,
    input  wire logic [ADDR_W-1:0]  i_killReg,
    output wb_entry_t               o_head,
    output logic [c_CNT_W-1:0]      o_count
);

    wb_entry_t          r_entries [DEPTH];
    logic [c_PTR_W-1:0] r_rdPtr;
    logic [c_PTR_W-1:0] r_wrPtr;
    logic [c_CNT_W-1:0] r_count;

    function automatic logic [c_PTR_W-1:0] nextPtr(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Later assignments win: a popped slot is invalidated after any kill
    // mark, and the caller never pushes into a full buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_killEn && r_entries[i].valid && (r_entries[i].regAddr == i_killReg)) begin
                    r_entries[i].killed <= 1'b1;
                end
                if (i_pop && (c_PTR_W'(i) == r_rdPtr)) begin
                    r_entries[i].valid <= 1'b0;
                end
                if (i_push && (c_PTR_W'(i) == r_wrPtr)) begin
                    r_entries[i] <= makeEntry(i_pushReg, i_pushData);
                end
            end
            if (i_pop) begin
                r_rdPtr <= nextPtr(r_rdPtr);
            end
            if (i_push) begin
                r_wrPtr <= nextPtr(r_wrPtr);
            end
            r_count <= r_count + c_CNT_W'(i_push) - c_CNT_W'(i_pop);
        end
    end

    assign o_head  = r_entries[r_rdPtr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Single-port register-file write-back arbiter: pipeline first,
//            then buffered long-latency results, then direct bypass.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
    parameter  int DATA_W  = cpu_pkg::DATA_W,
    parameter  int ADDR_W  = cpu_pkg::ADDR_W,
    parameter  int DEPTH   = 2,
    localparam int c_CNT_W = $clog2(DEPTH + 1)
) (
    input  wire logic   clk,
    input  wire logic   rst,
    wb_arbiter_if.slave bus
);

    cpu_pkg::wb_entry_t w_head;
    logic [c_CNT_W-1:0] w_count;

    logic               w_luAccept;
    logic               w_pipeWin;
    logic               w_bufBusy;
    logic               w_pop;
    logic               w_luLive;
    logic               w_bypass;
    logic               w_push;
    logic               w_wrEn;
    logic [ADDR_W-1:0]  w_wrReg;
    logic [DATA_W-1:0]  w_wrData;

    logic               r_regWrite;
    logic [ADDR_W-1:0]  r_writeReg;
    logic [DATA_W-1:0]  r_writeData;

    // Readiness looks only at registered occupancy, never at a same-cycle pop.
    assign bus.lu_ready = !rst && (w_count < c_CNT_W'(DEPTH));

    assign w_luAccept = bus.lu_valid && bus.lu_ready;
    assign w_pipeWin  = bus.pipe_wr_en && (bus.pipe_wr_reg != '0);
    assign w_bufBusy  = (w_count != '0);
    assign w_pop      = !w_pipeWin && w_bufBusy;

    // A pipeline write to the same register is younger, so the LU result dies.
    assign w_luLive = w_luAccept && (bus.lu_wr_reg != '0)
                      && !(w_pipeWin && (bus.lu_wr_reg == bus.pipe_wr_reg));
    assign w_bypass = w_luLive && !w_pipeWin && !w_bufBusy;
    assign w_push   = w_luLive && !w_bypass;

    always_comb begin
        w_wrEn   = 1'b0;
        w_wrReg  = r_writeReg;
        w_wrData = r_writeData;
        if (w_pipeWin) begin
            w_wrEn   = 1'b1;
            w_wrReg  = bus.pipe_wr_reg;
            w_wrData = bus.pipe_wr_data;
        end else if (w_bufBusy) begin
            w_wrEn   = w_head.valid && !w_head.killed;
            w_wrReg  = w_head.regAddr;
            w_wrData = w_head.data;
        end else if (w_bypass) begin
            w_wrEn   = 1'b1;
            w_wrReg  = bus.lu_wr_reg;
            w_wrData = bus.lu_wr_data;
        end
    end

    wb_buffer #(
        .DEPTH (DEPTH)
    ) u_buffer (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_pushReg  (bus.lu_wr_reg),
        .i_pushData (bus.lu_wr_data),
        .i_pop      (w_pop),
        .i_killEn   (w_pipeWin),
        .i_killReg  (bus.pipe_wr_reg),
        .o_head     (w_head),
        .o_count    (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_regWrite  <= 1'b0;
            r_writeReg  <= '0;
            r_writeData <= '0;
        end else begin
            r_regWrite <= w_wrEn;
            if (w_wrEn) begin
                r_writeReg  <= w_wrReg;
                r_writeData <= w_wrData;
            end
        end
    end

    assign bus.regWrite  = r_regWrite;
    assign bus.writeReg  = r_writeReg;
    assign bus.writeData = r_writeData;
    assign bus.buf_count = w_count;

endmodule
`default_nettype wire
